// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: feeder state encoding, padding constants and small helpers.
// Also used by the compression core.
package sha256_pkg;

    typedef enum logic [2:0] {
        FEED_IDLE = 3'd0,
        FEED_REQ  = 3'd1,
        FEED_CAP  = 3'd2,
        FEED_SEND = 3'd3,
        FEED_PAD  = 3'd4,
        FEED_FIN  = 3'd5
    } feeder_state_e;

    localparam logic [31:0] SHA256_PAD_MARKER  = 32'h8000_0000;
    localparam int unsigned SHA256_BLOCK_WORDS = 32'd16;

    // Blocks needed for 'words' message words plus marker and 64-bit length.
    function automatic int unsigned num_blocks(input int unsigned words);
        return (words + 32'd3 + 32'd15) / 32'd16;
    endfunction

    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sha256_block_feeder_if.sv
// Word stream from the block feeder to the compression core (valid/ready with block tags).
interface sha256_block_feeder_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_word_idx;
    logic        out_block_last;
    logic        out_msg_last;

    modport master (
        output out_valid, out_data, out_word_idx, out_block_last, out_msg_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_word_idx, out_block_last, out_msg_last,
        output out_ready
    );
endinterface

// File: rtl/sha256_pad_word_gen.sv
// Combinational padding generator: word value and position flags for a stream index.
module sha256_pad_word_gen
    import sha256_pkg::*;
(
    input  logic [11:0] word_idx,
    input  logic [10:0] num_words,
    output logic [31:0] pad_word,
    output logic        is_msg,
    output logic        block_last,
    output logic        msg_last
);

    logic [11:0] total_s;
    logic [31:0] len_s;

    // Classify the index and pick marker, zero fill or low length word.
    always_comb begin
        total_s    = 12'(num_blocks(32'(num_words)) * SHA256_BLOCK_WORDS);
        len_s      = {16'd0, num_words, 5'd0};
        is_msg     = (word_idx < {1'b0, num_words});
        block_last = (word_idx[3:0] == 4'd15);
        msg_last   = (word_idx == (total_s - 12'd1));
        if (word_idx == {1'b0, num_words}) begin
            pad_word = SHA256_PAD_MARKER;
        end else if (msg_last) begin
            pad_word = len_s;
        end else begin
            pad_word = 32'd0;
        end
    end

endmodule

// File: rtl/sha256_block_feeder.sv
// Reads a message from word memory, appends SHA-256 padding and streams 16-word blocks.
// Define SHA256_FEEDER_BYTESWAP_EN to byte-reverse message words (little-endian images).
module sha256_block_feeder
    import sha256_pkg::*;
#(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [15:0]                  message_addr,
    output logic                         mem_clk,
    output logic                         mem_we,
    output logic [15:0]                  mem_addr,
    input  logic [31:0]                  mem_read_data,
    sha256_block_feeder_if.master        out_if,
    output logic                         busy,
    output logic                         done
);

    if (NUM_OF_WORDS < 1 || NUM_OF_WORDS > 2047) begin : g_bad_len
        $error("sha256_block_feeder: NUM_OF_WORDS must be 1..2047");
    end

    localparam logic [10:0] NUM_W = 11'(NUM_OF_WORDS);

    feeder_state_e state_r, state_nxt_s;
    logic [15:0] base_r, base_d, mem_addr_r, mem_addr_d;
    logic [10:0] rd_ptr_r, rd_ptr_d;
    logic [11:0] cnt_r, cnt_d, sel_idx_s;
    logic [31:0] data_r, data_d, msg_word_s, gen_word_s;
    logic [3:0]  idx_r, idx_d;
    logic valid_r, valid_d, blast_r, blast_d, mlast_r, mlast_d;
    logic busy_r, busy_d, done_r, done_d, accept_s;
    logic gen_is_msg_s, gen_blast_s, gen_mlast_s;

`ifdef SHA256_FEEDER_BYTESWAP_EN
    assign msg_word_s = byte_swap(mem_read_data);
`else
    assign msg_word_s = mem_read_data;
`endif

    assign accept_s  = valid_r & out_if.out_ready;
    // CAP tags the word being fetched; elsewhere we look one word ahead.
    assign sel_idx_s = (state_r == FEED_CAP) ? cnt_r : (cnt_r + 12'd1);

    sha256_pad_word_gen u_pad_gen (
        .word_idx   (sel_idx_s),
        .num_words  (NUM_W),
        .pad_word   (gen_word_s),
        .is_msg     (gen_is_msg_s),
        .block_last (gen_blast_s),
        .msg_last   (gen_mlast_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_r <= FEED_IDLE;
        else          state_r <= state_nxt_s;
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            FEED_IDLE: state_nxt_s = start ? FEED_REQ : FEED_IDLE;
            FEED_REQ:  state_nxt_s = FEED_CAP;
            FEED_CAP:  state_nxt_s = FEED_SEND;
            FEED_SEND: begin
                if (accept_s) state_nxt_s = gen_is_msg_s ? FEED_REQ : FEED_PAD;
                else          state_nxt_s = FEED_SEND;
            end
            FEED_PAD: begin
                if (accept_s) state_nxt_s = mlast_r ? FEED_FIN : FEED_PAD;
                else          state_nxt_s = FEED_PAD;
            end
            FEED_FIN:  state_nxt_s = FEED_IDLE;
            default:   state_nxt_s = FEED_IDLE;
        endcase
    end

    // Output/datapath next values; all outputs leave through registers.
    always_comb begin
        base_d = base_r;  rd_ptr_d = rd_ptr_r;  cnt_d = cnt_r;  mem_addr_d = mem_addr_r;
        data_d = data_r;  valid_d = valid_r;    idx_d = idx_r;
        blast_d = blast_r;  mlast_d = mlast_r;
        case (state_r)
            FEED_IDLE: begin
                if (start) begin
                    base_d = message_addr;  mem_addr_d = message_addr;
                    rd_ptr_d = 11'd0;       cnt_d = 12'd0;
                end else begin
                    valid_d = 1'b0;
                end
            end
            FEED_CAP: begin
                data_d  = msg_word_s;  valid_d = 1'b1;  idx_d = sel_idx_s[3:0];
                blast_d = gen_blast_s; mlast_d = gen_mlast_s;
                rd_ptr_d = rd_ptr_r + 11'd1;
                // Park the address on the last message word once nothing is left to read.
                if ((rd_ptr_r + 11'd1) < NUM_W) begin
                    mem_addr_d = base_r + {5'd0, rd_ptr_r} + 16'd1;
                end else begin
                    mem_addr_d = mem_addr_r;
                end
            end
            FEED_SEND, FEED_PAD: begin
                if (accept_s) begin
                    cnt_d = cnt_r + 12'd1;
                    if (gen_is_msg_s || (state_r == FEED_PAD && mlast_r)) begin
                        valid_d = 1'b0;
                    end else begin
                        valid_d = 1'b1;  data_d = gen_word_s;  idx_d = sel_idx_s[3:0];
                        blast_d = gen_blast_s;  mlast_d = gen_mlast_s;
                    end
                end else begin
                    valid_d = valid_r;
                end
            end
            FEED_REQ, FEED_FIN: valid_d = 1'b0;
            default:            valid_d = 1'b0;
        endcase
        busy_d = (state_nxt_s != FEED_IDLE);
        done_d = (state_nxt_s == FEED_FIN);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_r <= 16'd0;  mem_addr_r <= 16'd0;  rd_ptr_r <= 11'd0;  cnt_r <= 12'd0;
            data_r <= 32'd0;  valid_r <= 1'b0;  idx_r <= 4'd0;
            blast_r <= 1'b0;  mlast_r <= 1'b0;  busy_r <= 1'b0;  done_r <= 1'b0;
        end else begin
            base_r <= base_d;  mem_addr_r <= mem_addr_d;  rd_ptr_r <= rd_ptr_d;  cnt_r <= cnt_d;
            data_r <= data_d;  valid_r <= valid_d;  idx_r <= idx_d;
            blast_r <= blast_d;  mlast_r <= mlast_d;  busy_r <= busy_d;  done_r <= done_d;
        end
    end

    assign mem_clk               = clk;
    assign mem_we                = 1'b0;
    assign mem_addr              = mem_addr_r;
    assign out_if.out_valid      = valid_r;
    assign out_if.out_data       = data_r;
    assign out_if.out_word_idx   = idx_r;
    assign out_if.out_block_last = blast_r;
    assign out_if.out_msg_last   = mlast_r;
    assign busy                  = busy_r;
    assign done                  = done_r;

endmodule

// File: tb/tb_sha256_block_feeder.sv
// Randomised self-checking bench: three feeder instances (20, 13 and 4 words) against a padding model.
module tb_sha256_block_feeder;

    logic clk = 1'b0;
    logic reset_n;
    logic [2:0] start_v;
    logic [15:0] message_addr;
    logic [31:0] mem_rd;
    logic rdy;
    int sel;

    always #5 clk = ~clk;

    sha256_block_feeder_if bus20 ();
    sha256_block_feeder_if bus13 ();
    sha256_block_feeder_if bus4 ();
    assign bus20.out_ready = rdy;
    assign bus13.out_ready = rdy;
    assign bus4.out_ready  = rdy;

    logic [15:0] addr20, addr13, addr4;
    logic mclk20, mclk13, mclk4, we20, we13, we4;
    logic busy20, busy13, busy4, done20, done13, done4;

    sha256_block_feeder #(.NUM_OF_WORDS(20)) u20 (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]), .message_addr(message_addr),
        .mem_clk(mclk20), .mem_we(we20), .mem_addr(addr20), .mem_read_data(mem_rd),
        .out_if(bus20), .busy(busy20), .done(done20));
    sha256_block_feeder #(.NUM_OF_WORDS(13)) u13 (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]), .message_addr(message_addr),
        .mem_clk(mclk13), .mem_we(we13), .mem_addr(addr13), .mem_read_data(mem_rd),
        .out_if(bus13), .busy(busy13), .done(done13));
    sha256_block_feeder #(.NUM_OF_WORDS(4)) u4 (
        .clk(clk), .reset_n(reset_n), .start(start_v[2]), .message_addr(message_addr),
        .mem_clk(mclk4), .mem_we(we4), .mem_addr(addr4), .mem_read_data(mem_rd),
        .out_if(bus4), .busy(busy4), .done(done4));

    // Observation mux onto the instance under test.
    logic o_valid, o_bl, o_ml, o_busy, o_done, o_we;
    logic [31:0] o_data;
    logic [3:0]  o_idx;
    logic [15:0] o_addr;
    always_comb begin
        case (sel)
            1: begin o_valid = bus13.out_valid; o_data = bus13.out_data; o_idx = bus13.out_word_idx;
                     o_bl = bus13.out_block_last; o_ml = bus13.out_msg_last; o_addr = addr13;
                     o_busy = busy13; o_done = done13; o_we = we13; end
            2: begin o_valid = bus4.out_valid; o_data = bus4.out_data; o_idx = bus4.out_word_idx;
                     o_bl = bus4.out_block_last; o_ml = bus4.out_msg_last; o_addr = addr4;
                     o_busy = busy4; o_done = done4; o_we = we4; end
            default: begin o_valid = bus20.out_valid; o_data = bus20.out_data; o_idx = bus20.out_word_idx;
                     o_bl = bus20.out_block_last; o_ml = bus20.out_msg_last; o_addr = addr20;
                     o_busy = busy20; o_done = done20; o_we = we20; end
        endcase
    end

    logic [31:0] mem [0:65535];
    always @(posedge clk) mem_rd <= mem[o_addr];

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] got_q[$];
    logic [15:0] addr_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: stream word k of an n-word message at base.
    function automatic logic [31:0] model_word(input int n, input int k, input logic [15:0] base);
        int total;
        logic [15:0] a;
        logic [31:0] w;
        total = 16 * ((n + 3 + 15) / 16);
        if (k < n) begin
            a = base + 16'(k);
            w = mem[a];
`ifdef SHA256_FEEDER_BYTESWAP_EN
            w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
            return w;
        end
        if (k == n)         return 32'h8000_0000;
        if (k == total - 1) return 32'(n * 32);
        return 32'd0;
    endfunction

    task automatic run_msg(input int dsel, input int n, input logic [15:0] base,
                           input int rdy_pct, input int abort_at);
        int total, k, cyc, first_valid, dones;
        logic held;
        logic [37:0] h_vec;
        logic [15:0] ea;
        total = 16 * ((n + 3 + 15) / 16);
        got_q.delete(); addr_q.delete();
        sel = dsel; rdy = 1'b0; message_addr = base;
        @(negedge clk); start_v[dsel] = 1'b1;
        @(negedge clk); start_v = 3'd0; message_addr = 16'h0;
        addr_q.push_back(o_addr);
        k = 0; cyc = 0; first_valid = -1; dones = 0; held = 1'b0; h_vec = '0;
        while (k < total && cyc < 3000) begin
            if (o_busy && o_addr != addr_q[$]) addr_q.push_back(o_addr);
            if (o_done) dones++;
            if (o_valid && first_valid < 0) first_valid = cyc;
            if (held) check("stall_stable", {26'd0, o_valid, o_data, o_idx, o_bl}, {26'd0, 1'b1, h_vec[37:1]});
            if (held && abort_at == k) begin
                reset_n = 1'b0;
                #1;
                check("rst_valid", {63'd0, o_valid}, 64'd0);
                check("rst_busy", {63'd0, o_busy}, 64'd0);
                check("rst_tags", {o_data, o_idx, o_bl, o_ml}, 64'd0);
                @(negedge clk); reset_n = 1'b1;
                return;
            end
            rdy = ($urandom_range(99) < rdy_pct) && (abort_at != k);
            if (o_valid && rdy) begin
                check($sformatf("data[%0d]", k), {32'd0, o_data}, {32'd0, model_word(n, k, base)});
                check($sformatf("tags[%0d]", k), {61'd0, o_idx == 4'(k % 16), o_bl, o_ml},
                      {61'd0, 1'b1, (k % 16) == 15, k == total - 1});
                got_q.push_back(o_data);
                k++; held = 1'b0;
            end else if (o_valid) begin
                held = 1'b1; h_vec = {o_data, o_idx, o_bl, o_ml};
            end else begin
                held = 1'b0;
            end
            @(negedge clk); cyc++;
        end
        rdy = 1'b0;
        check("word_count", 64'(k), 64'(total));
        check("first_valid_latency", 64'(first_valid), 64'd2);
        check("done_pulse", {62'd0, o_done, o_valid}, {62'd0, 1'b1, 1'b0});
        dones = dones + (o_done ? 1 : 0);
        @(negedge clk);
        dones = dones + (o_done ? 1 : 0);
        check("done_once", 64'(dones), 64'd1);
        check("idle_after", {62'd0, o_busy, o_we}, 64'd0);
        check("addr_count", 64'(addr_q.size()), 64'(n));
        for (int i = 0; i < n && i < addr_q.size(); i++) begin
            ea = base + 16'(i);
            check($sformatf("mem_addr[%0d]", i), {48'd0, addr_q[i]}, {48'd0, ea});
        end
    endtask

    initial begin
        reset_n = 1'b0; start_v = 3'd0; rdy = 1'b0; sel = 0; message_addr = 16'h0;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        for (int i = 0; i < 20; i++) mem[16'h1000 + i] = 32'(i + 1);
        repeat (3) @(negedge clk);
        check("reset_state", {o_valid, o_busy, o_done, o_bl, o_ml, o_idx, o_data, o_addr},
              64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 20 words, always ready
        run_msg(0, 20, 16'h1000, 100, -1);
        check("n20_w19", {32'd0, got_q[19]}, 64'h14);
        check("n20_marker", {32'd0, got_q[20]}, 64'h8000_0000);
        check("n20_len", {32'd0, got_q[31]}, 64'h280);

        // exactly one block
        run_msg(1, 13, 16'h2000, 100, -1);
        check("n13_size", 64'(got_q.size()), 64'd16);
        check("n13_marker", {32'd0, got_q[13]}, 64'h8000_0000);
        check("n13_hi_len", {32'd0, got_q[14]}, 64'd0);
        check("n13_len", {32'd0, got_q[15]}, 64'h1A0);

        // backpressure
        run_msg(0, 20, 16'h1000, 50, -1);
        run_msg(0, 20, 16'h4321, 30, -1);

        // address wrap
        run_msg(2, 4, 16'hFFFE, 60, -1);
        check("wrap_addr2", {48'd0, addr_q[2]}, 64'h0000);

        // reset while word 7 is stalled, then a clean message
        run_msg(0, 20, 16'h1000, 50, 7);
        repeat (2) @(negedge clk);
        run_msg(0, 20, 16'h1000, 70, -1);

        // byte order of message words
        mem[16'h3000] = 32'h0123_4567;
        run_msg(0, 20, 16'h3000, 100, -1);
`ifdef SHA256_FEEDER_BYTESWAP_EN
        check("swap_w0", {32'd0, got_q[0]}, 64'h6745_2301);
`else
        check("swap_w0", {32'd0, got_q[0]}, 64'h0123_4567);
`endif
        check("swap_marker", {32'd0, got_q[20]}, 64'h8000_0000);
        check("swap_len", {32'd0, got_q[31]}, 64'h280);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sha256_block_feeder.md
Name: sha256_block_feeder

Overview:
- Upstream stage of the SHA-256 compression core.
- On start, reads NUM_OF_WORDS 32-bit message words from word-addressed synchronous memory beginning at message_addr.
- Appends standard SHA-256 padding: 0x80000000 marker, zero fill, then 64-bit bit-length.
- Streams the resulting 16-word blocks to the core over a valid/ready word interface, tagged with word index, block-last and message-last.

Parameters:
- NUM_OF_WORDS, 20, message length in 32-bit words; legal range 1..2047; elaboration error outside this range.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  begin one message; sampled only in IDLE
- message_addr  input  16  word address of message word 0; latched on accepted start
- mem_clk  output  1  equals clk
- mem_we  output  1  tied 0; read-only master
- mem_addr  output  16  read address = base + rd_ptr, modulo 2^16
- mem_read_data  input  32  read data, valid the cycle after mem_addr is presented
- out_valid  output  1  out_data and tags valid
- out_ready  input  1  consumer accepts when out_valid && out_ready
- out_data  output  32  message or padding word
- out_word_idx  output  4  word position within current block, 0..15
- out_block_last  output  1  high when out_word_idx==15
- out_msg_last  output  1  high on final word of final block
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse after the final word is accepted

Behaviour:
- Reset values: state IDLE; out_valid, out_data, out_word_idx, out_block_last, out_msg_last, busy, done, rd_ptr and word counter all 0; mem_addr = 0.
- Derived constants:
  - TOTAL_WORDS = 16*NUM_BLOCKS, with NUM_BLOCKS = ceil((NUM_OF_WORDS+3)/16).
  - Length word = NUM_OF_WORDS*32, 32 bits; the high length word is always 0.
- States: IDLE, REQ, CAP, SEND, PAD, FIN.
- IDLE:
  - start=1 latches message_addr, clears counters, goes to REQ.
  - start is ignored in every other state.
- REQ: mem_addr = base+rd_ptr; go to CAP.
- CAP: latch mem_read_data into out_data, assert out_valid, rd_ptr++, go to SEND.
- SEND:
  - Hold out_data and tags stable while out_valid && !out_ready.
  - On accept with more message words remaining: deassert out_valid, go to REQ.
  - On accept of the last message word: present the first pad word next cycle (out_valid stays high), go to PAD.
  - Message-word throughput is one word per 3 cycles with out_ready held high.
- PAD:
  - Word k = NUM_OF_WORDS is 0x80000000.
  - Words up to TOTAL_WORDS-3 are 0.
  - Word TOTAL_WORDS-2 is 0 (high length word).
  - Word TOTAL_WORDS-1 is the length word.
  - One word per accepted cycle, no bubbles.
- Accepting word TOTAL_WORDS-1 goes to FIN.
- FIN: drop out_valid, pulse done for one cycle, return to IDLE.
- Tags: out_word_idx = word counter mod 16, wraps 15 to 0 across blocks. out_block_last and out_msg_last are combinational from the counter and registered together with out_data.
- Latency: start sampled at edge E0, first out_valid high after edge E2.
- Wrap-around: mem_addr wraps modulo 2^16 silently.
- Boundary cases:
  - NUM_OF_WORDS=13 fills exactly one block.
  - NUM_OF_WORDS=14 spills to two blocks; the marker goes in word 14.
- reset_n asserted mid-message: immediate return to reset values. There is no partial-message recovery; the consumer must also be reset.
- done and a new start in the same cycle cannot overlap: start is ignored during FIN.

Optional Feature:
- SHA256_FEEDER_BYTESWAP_EN defined: message words are byte-reversed before latching into out_data (0x01234567 becomes 0x67452301), for little-endian memory images. Padding and length words are never swapped.
- Undefined: message words pass through unmodified.

Decomposition:
- sha256_pkg holds:
  - feeder state enum typedef
  - SHA256_PAD_MARKER = 32'h80000000
  - SHA256_BLOCK_WORDS = 16
  - function num_blocks(words) returning ceil((words+3)/16)
- The compression core shares this package.
- One sub-module, sha256_pad_word_gen: combinational. Inputs are the word counter and NUM_OF_WORDS; outputs are the pad word and the is_msg/last flags. The feeder instantiates it once.

Test Plan:
- NUM_OF_WORDS=20, memory words 0x00000001..0x00000014, out_ready=1 -> expected stream:
  - 32 words; words 0..19 equal memory.
  - word 20 = 0x80000000; 21..30 = 0; word 31 = 0x00000280.
  - out_block_last on words 15 and 31; out_msg_last only on word 31; done pulses once.
- NUM_OF_WORDS=13 -> 16 words; word 13 = 0x80000000, word 14 = 0, word 15 = 0x000001A0; block_last and msg_last together on word 15.
- Random out_ready backpressure at 50%, NUM_OF_WORDS=20 -> same 32-word sequence; out_data and tags stable every stalled cycle; no word dropped or duplicated.
- message_addr=0xFFFE, NUM_OF_WORDS=4 -> mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- reset_n pulsed low while word 7 is held under backpressure -> out_valid=0, busy=0 immediately; a subsequent start produces a full correct stream from word 0.
- SHA256_FEEDER_BYTESWAP_EN defined, memory word0 = 0x01234567 -> out_data word0 = 0x67452301; word 20 still 0x80000000 and word 31 still 0x00000280.
